// File: rtl/mem_if_pkg.sv
// Shared types and constants for the core-to-memory load/store/fetch port.
// Holds the FSM state encoding, funct3 size codes and the access legality check.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memif_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fetches are always word accesses; funct3 only matters for loads/stores.
  function automatic logic access_illegal(input logic is_fetch, input logic [2:0] f3,
                                          input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    if (is_fetch) begin
      bad = (lane != 2'b00);
    end else begin
      case (f3)
        F3_B, F3_BU: bad = 1'b0;
        F3_H, F3_HU: bad = lane[0];
        F3_W:        bad = (lane != 2'b00);
        default:     bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_interface_load_extend.sv
// Selects the addressed byte/half of a bus read word and sign- or zero-extends it.
// Fetches and word loads pass the bus word through unchanged.
module load_extend
  import mem_if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  input  logic            is_fetch,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;

  // Lane select and extension by access size.
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = lane[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    if (is_fetch) begin
      data = rdata;
    end else begin
      case (funct3)
        F3_B:    data = {{(XLEN-8){byte_s[7]}}, byte_s};
        F3_BU:   data = {{(XLEN-8){1'b0}}, byte_s};
        F3_H:    data = {{(XLEN-16){half_s[15]}}, half_s};
        F3_HU:   data = {{(XLEN-16){1'b0}}, half_s};
        default: data = rdata;
      endcase
    end
  end

endmodule

// File: rtl/mem_interface.sv
// Load/store/fetch port between the multicycle core and a valid/ready memory bus.
// Three-state FSM (IDLE -> REQ -> DONE) with store lane steering and a bus timeout.
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReq,
  input  logic            MemWrite,
  input  logic            IsFetch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] Adr,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Stall,
  output logic            MisalignErr,
  output logic            BusErr,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  memif_state_t    state_r;
  logic [CW-1:0]   wait_cnt_r;
  logic [1:0]      lane_r;
  logic [2:0]      f3_r;
  logic            fetch_r;
  logic            illegal_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] ext_s;

  assign illegal_s = access_illegal(IsFetch, funct3, Adr[1:0]);
  assign Stall     = ((state_r == IDLE) && MemReq) || (state_r == REQ);

  // Byte enables and lane-replicated write data from the requested size.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = WriteData;
    if (IsFetch) begin
      be_s    = 4'b1111;
      wdata_s = WriteData;
    end else begin
      case (funct3[1:0])
        2'b00: begin
          be_s    = 4'b0001 << Adr[1:0];
          wdata_s = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_s    = 4'b0011 << {Adr[1], 1'b0};
          wdata_s = {2{WriteData[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = WriteData;
        end
      endcase
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata    (mem_rdata),
    .lane     (lane_r),
    .funct3   (f3_r),
    .is_fetch (fetch_r),
    .data     (ext_s)
  );

  // Access FSM; bus outputs hold steady for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= '0;
      lane_r      <= 2'b00;
      f3_r        <= 3'b000;
      fetch_r     <= 1'b0;
      ReadData    <= '0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_wdata   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_cnt_r <= '0;
          if (MemReq) begin
            if (illegal_s) begin
              MisalignErr <= 1'b1;
              state_r     <= DONE;
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= {Adr[XLEN-1:2], 2'b00};
              mem_we    <= MemWrite & ~IsFetch;
              mem_be    <= be_s;
              mem_wdata <= wdata_s;
              lane_r    <= Adr[1:0];
              f3_r      <= funct3;
              fetch_r   <= IsFetch;
              state_r   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (!mem_we) begin
              ReadData <= ext_s;
            end
            state_r <= DONE;
          end else if (wait_cnt_r == WAIT_LAST) begin
            mem_valid <= 1'b0;
            BusErr    <= 1'b1;
            ReadData  <= '0;
            state_r   <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        DONE: begin
          MisalignErr <= 1'b0;
          BusErr      <= 1'b0;
          wait_cnt_r  <= '0;
          state_r     <= IDLE;
        end
        default: begin
          mem_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
